// File: rtl/bz_sound_mixer.sv
// Four-voice sample mixer: snapshot on the 48 kHz strobe, one multiply-accumulate
// per channel, then divide by 8 and saturate to a signed 16-bit output sample.
//
// state | meaning
// IDLE  | waiting for a sample strobe
// MAC0  | accumulate channel 0 (bang/crash voice)
// MAC1  | accumulate channel 1
// MAC2  | accumulate channel 2
// MAC3  | accumulate channel 3
// SAT   | shift, clamp and load the output sample
module bz_sound_mixer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en_48KHz,
    input  logic [16:0] ch0_in,
    input  logic [16:0] ch1_in,
    input  logic [16:0] ch2_in,
    input  logic [16:0] ch3_in,
    input  logic [3:0]  gain0,
    input  logic [3:0]  gain1,
    input  logic [3:0]  gain2,
    input  logic [3:0]  gain3,
    input  logic        mute,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        MAC3 = 3'd4,
        SAT  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [3:0][16:0]   ch_snap;
    logic [3:0][3:0]    gain_snap;
    logic               mute_snap;
    logic signed [23:0] acc;

    logic               snap_load;
    logic               acc_add;
    logic               out_load;
    logic [1:0]         mac_sel;

    logic signed [17:0] mac_diff;
    logic signed [22:0] mac_prod;
    logic signed [23:0] acc_shr;
    logic [15:0]        sat_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        snap_load = 1'b0;
        acc_add   = 1'b0;
        out_load  = 1'b0;
        mac_sel   = 2'd0;
        case (state)
            IDLE: begin
                if (clk_en_48KHz) begin
                    snap_load = 1'b1;
                    state_nxt = MAC0;
                end
            end
            MAC0: begin
                acc_add   = 1'b1;
                mac_sel   = 2'd0;
                state_nxt = MAC1;
            end
            MAC1: begin
                acc_add   = 1'b1;
                mac_sel   = 2'd1;
                state_nxt = MAC2;
            end
            MAC2: begin
                acc_add   = 1'b1;
                mac_sel   = 2'd2;
                state_nxt = MAC3;
            end
            MAC3: begin
                acc_add   = 1'b1;
                mac_sel   = 2'd3;
                state_nxt = SAT;
            end
            SAT: begin
                out_load  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Offset removal widens to 18 bits so full-scale 131071 maps to +98303.
    assign mac_diff = $signed({1'b0, ch_snap[mac_sel]}) - 18'sd32768;
    assign mac_prod = 23'(mac_diff) * 23'($signed({1'b0, gain_snap[mac_sel]}));

    assign acc_shr = acc >>> 3;

    always_comb begin
        sat_val = acc_shr[15:0];
        if (acc_shr > 24'sd32767) begin
            sat_val = 16'h7fff;
        end else if (acc_shr < -24'sd32768) begin
            sat_val = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_snap   <= '0;
            gain_snap <= '0;
            mute_snap <= 1'b0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (snap_load) begin
                ch_snap   <= {ch3_in, ch2_in, ch1_in, ch0_in};
                gain_snap <= {gain3, gain2, gain1, gain0};
                mute_snap <= mute;
                acc       <= '0;
            end else if (acc_add) begin
                acc <= acc + 24'(mac_prod);
            end
            if (out_load) begin
                out       <= mute_snap ? 16'h0000 : sat_val;
                out_valid <= 1'b1;
            end
            // A strobe outside IDLE is dropped; only the sticky flag records it.
            if (clk_en_48KHz && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bz_sound_mixer.sv
// Randomized self-checking bench for bz_sound_mixer against an arithmetic mixing model.
module tb_bz_sound_mixer;

    logic        clk;
    logic        reset_n;
    logic        clk_en_48KHz;
    logic [16:0] ch0_in, ch1_in, ch2_in, ch3_in;
    logic [3:0]  gain0, gain1, gain2, gain3;
    logic        mute;
    logic [15:0] out;
    logic        out_valid;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    int ch_v [4];
    int g_v  [4];
    int mute_v;
    int exp_out = 0;
    int exp_ovr = 0;

    bz_sound_mixer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clk_en_48KHz (clk_en_48KHz),
        .ch0_in       (ch0_in),
        .ch1_in       (ch1_in),
        .ch2_in       (ch2_in),
        .ch3_in       (ch3_in),
        .gain0        (gain0),
        .gain1        (gain1),
        .gain2        (gain2),
        .gain3        (gain3),
        .mute         (mute),
        .out          (out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mixed sample = floor(sum((ch - 32768) * gain) / 8), clamped to 16-bit signed.
    function automatic int ref_mix();
        longint s = 0;
        longint y;
        for (int k = 0; k < 4; k++) s += longint'(ch_v[k] - 32768) * longint'(g_v[k]);
        if (s >= 0) y = s / 8;
        else        y = -((-s + 7) / 8);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        if (mute_v != 0) y = 0;
        return int'(y);
    endfunction

    task automatic drive_inputs();
        ch0_in = 17'(ch_v[0]); ch1_in = 17'(ch_v[1]);
        ch2_in = 17'(ch_v[2]); ch3_in = 17'(ch_v[3]);
        gain0  = 4'(g_v[0]);   gain1  = 4'(g_v[1]);
        gain2  = 4'(g_v[2]);   gain3  = 4'(g_v[3]);
        mute   = (mute_v != 0);
    endtask

    task automatic scramble_inputs();
        ch0_in = 17'($urandom); ch1_in = 17'($urandom);
        ch2_in = 17'($urandom); ch3_in = 17'($urandom);
        gain0  = 4'($urandom);  gain1  = 4'($urandom);
        gain2  = 4'($urandom);  gain3  = 4'($urandom);
        mute   = 1'($urandom);
    endtask

    task automatic set_all(input int c, input int g);
        for (int k = 0; k < 4; k++) begin
            ch_v[k] = c;
            g_v[k]  = g;
        end
        mute_v = 0;
    endtask

    // Strobe one sample, optionally re-strobe at E2 to provoke an overrun.
    task automatic send_sample(input string tag, input bit overlap);
        int e;
        e = ref_mix();
        drive_inputs();
        clk_en_48KHz = 1'b1;
        step();
        clk_en_48KHz = 1'b0;
        scramble_inputs();
        chk({tag, "_valid_e0"}, int'(out_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            if (overlap && i == 2) clk_en_48KHz = 1'b1;
            step();
            clk_en_48KHz = 1'b0;
            if (overlap && i == 2) exp_ovr = 1;
            chk({tag, "_valid_early"}, int'(out_valid), 0);
            chk({tag, "_hold"}, int'($signed(out)), exp_out);
        end
        step();
        exp_out = e;
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_out"}, int'($signed(out)), exp_out);
        chk({tag, "_overrun"}, int'(overrun), exp_ovr);
    endtask

    initial begin
        reset_n      = 1'b0;
        clk_en_48KHz = 1'b0;
        set_all(32768, 0);
        drive_inputs();
        #3;
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        set_all(32768, 15);
        send_sample("silence", 1'b0);

        set_all(32768, 0);
        ch_v[0] = 40768; g_v[0] = 8;
        send_sample("single", 1'b0);

        set_all(131071, 15);
        send_sample("sat_pos", 1'b0);

        set_all(0, 15);
        send_sample("sat_neg", 1'b0);

        set_all(32768, 0);
        ch_v[0] = 32767; g_v[0] = 1;
        send_sample("floor", 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       ch_v[k] = 0;
                    1:       ch_v[k] = 131071;
                    default: ch_v[k] = int'($urandom_range(0, 131071));
                endcase
                g_v[k] = int'($urandom_range(0, 15));
            end
            mute_v = ($urandom_range(0, 7) == 0) ? 1 : 0;
            send_sample("rand", 1'b0);
        end

        set_all(32768, 0);
        ch_v[1] = 50000; g_v[1] = 3; ch_v[2] = 1000; g_v[2] = 7;
        send_sample("ovr", 1'b1);
        step();
        chk("ovr_single_valid", int'(out_valid), 0);

        set_all(60000, 2);
        send_sample("ovr_sticky", 1'b0);

        set_all(98303, 15);
        drive_inputs();
        clk_en_48KHz = 1'b1;
        step();
        clk_en_48KHz = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #2;
        exp_out = 0;
        exp_ovr = 0;
        chk("midrst_out", int'(out), 0);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        #2;
        reset_n = 1'b1;

        set_all(32768, 0);
        ch_v[0] = 98303; g_v[0] = 15; mute_v = 1;
        send_sample("mute", 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 4; k++) begin
                ch_v[k] = int'($urandom_range(0, 131071));
                g_v[k]  = int'($urandom_range(0, 15));
            end
            mute_v = 0;
            send_sample("post", 1'b0);
        end

        step();
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_hold", int'($signed(out)), exp_out);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bz_sound_mixer.md
BZ_SOUND_MIXER -- requirements
Module: bz_sound_mixer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; one clock; asynchronous and active-low.
REQ-003 SHALL have port clk_en_48KHz, input, 1, sample strobe, one clk wide, at most one per 6 clk.
REQ-004 SHALL have ports ch0_in..ch3_in, input, 17 each, offset-binary channel samples; 32768 = silence; ch0 is the bang/crash voice.
REQ-005 SHALL have ports gain0..gain3, input, 4 each, unsigned per-channel gain 0..15.
REQ-006 SHALL have port mute, input, 1, forces output sample to 0.
REQ-007 SHALL have port out, output, 16, signed two's-complement mixed sample.
REQ-008 SHALL have port out_valid, output, 1, one-clk pulse when out updates.
REQ-009 SHALL have port overrun, output, 1, sticky flag: a strobe arrived while busy.

Function
REQ-010 SHALL implement FSM states IDLE, MAC0, MAC1, MAC2, MAC3, SAT; reset state IDLE.
REQ-011 SHALL, in IDLE with clk_en_48KHz=1 at edge E0, snapshot all ch*_in, gain*, and mute, clear accumulator, and go to MAC0.
REQ-012 SHALL, in MACn at edge E(n+1), add (snapshot chn_in - 32768) * gainn to the accumulator, then advance; MAC3 goes to SAT.
REQ-013 SHALL form the offset removal as 18-bit signed (range -32768..98303) and the product with gain as unsigned 4-bit, zero-extended.
REQ-014 SHALL use a 24-bit signed accumulator; worst case +5,898,180 / -1,966,080 never wraps.
REQ-015 SHALL, in SAT at edge E5, compute acc arithmetic-shift-right 3 (floor toward -inf), clamp to [-32768, 32767], load out, and go to IDLE.
REQ-016 SHALL load out with 0 at E5 when the snapshot mute=1, regardless of accumulator.
REQ-017 SHALL assert out_valid for exactly the one clk following E5; otherwise 0.
REQ-018 SHALL hold out stable between updates.
REQ-019 SHALL give latency: out/out_valid change exactly 5 clk edges after the strobe edge E0.
REQ-020 SHALL ignore a strobe seen in any state other than IDLE, leave the in-flight computation unaffected, and set overrun=1.
REQ-021 SHALL accept a strobe in IDLE on the same clk out_valid is high, i.e. back-to-back at 6-clk spacing, with no overrun.
REQ-022 SHALL keep overrun at 1 until reset.
REQ-023 SHALL ignore input changes after E0 for the current sample; only the snapshot is used.

Reset
REQ-024 SHALL, while reset_n=0, force state IDLE, accumulator 0, snapshots 0, out 0, out_valid 0, overrun 0, independent of clk.
REQ-025 SHALL abort any in-flight computation on reset assertion mid-operation; no out_valid pulse for that sample after release.
REQ-026 SHALL, on the first edge after reset_n deasserts, accept a strobe normally.

Verification
REQ-027 SHALL cover silence: all ch=32768, all gains=15, strobe -> out=0, out_valid pulse 5 clk later.
REQ-028 SHALL cover single channel: ch0=40768, gain0=8, other gains=0 -> acc=64000 -> out=8000.
REQ-029 SHALL cover saturation: all ch=131071, gains=15 -> out=32767; all ch=0, gains=15 -> out=-32768.
REQ-030 SHALL cover floor rounding: ch0=32767, gain0=1, others 0 -> acc=-1 -> out=-1.
REQ-031 SHALL cover overrun: second strobe 2 clk after the first -> out from the first sample only, single out_valid, overrun=1 and stays 1.
REQ-032 SHALL cover reset mid-MAC2 and mute: reset -> out=0, out_valid never pulses; then mute=1 with ch0=98303, gain0=15 -> out=0.
